// File: rtl/aes_key_schedule.sv
// aes_key_schedule: AES key expansion, one 32-bit word per clock, into a
// round-key word RAM with a registered 128-bit read port.
// Define AES_KEY_256_EN to add AES-192/AES-256 support (default: AES-128 only).
module aes_key_schedule #(
`ifdef AES_KEY_256_EN
  parameter int unsigned WORDS_MAX = 60
`else
  parameter int unsigned WORDS_MAX = 44
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  input  logic [3:0]   round_key_no,
  output logic [127:0] key,
  output logic [3:0]   rounds_total,
  output logic         busy,
  output logic         key_valid
);

`ifdef AES_KEY_256_EN
  localparam int unsigned HIST = 8;
`else
  localparam int unsigned HIST = 4;
`endif
  localparam int unsigned HW = $clog2(HIST);
  localparam int unsigned RW = $clog2(WORDS_MAX);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  function automatic logic [7:0] get_sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {get_sbox(w[31:24]), get_sbox(w[23:16]), get_sbox(w[15:8]), get_sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     hist [HIST];
  logic [HW-1:0]   nk_m1;
  logic [HW-1:0]   imod;
  logic [3:0]      nr;
  logic [RW-1:0]   i_q;
  logic [7:0]      rcon;
  logic [31:0]     prev, t, w_new;
  logic [31:0]     ram [WORDS_MAX];
  logic [127:0]    rd;
  logic [RW-1:0]   idx;

`ifndef AES_KEY_256_EN
  logic unused_ok;
  assign unused_ok = ^{key_size, key_in[255:128]};
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = EXPAND;
      EXPAND:  if (i_q == RW'({nr, 2'b11})) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == LOAD) || (state_q == EXPAND);
    key_valid = (state_q == DONE);
  end

  // history holds w[i-Nk] at index 0 up to w[i-1] at index Nk-1
  always_comb begin
    prev = hist[nk_m1];
    t    = prev;
    if (imod == '0)
      t = sub_word({prev[7:0], prev[31:8]}) ^ {24'h0, rcon};
`ifdef AES_KEY_256_EN
    else if (nk_m1 == HW'(7) && imod == HW'(4))
      t = sub_word(prev);
`endif
    w_new = hist[0] ^ t;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int unsigned k = 0; k < HIST; k++) hist[k[HW-1:0]] <= '0;
      nk_m1        <= HW'(3);
      nr           <= 4'd10;
      imod         <= '0;
      i_q          <= '0;
      rcon         <= 8'h01;
      rounds_total <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          for (int unsigned k = 0; k < HIST; k++) hist[k[HW-1:0]] <= key_in[32*k +: 32];
`ifdef AES_KEY_256_EN
          case (key_size)
            2'd1:    begin nk_m1 <= HW'(5); nr <= 4'd12; end
            2'd2:    begin nk_m1 <= HW'(7); nr <= 4'd14; end
            default: begin nk_m1 <= HW'(3); nr <= 4'd10; end
          endcase
`else
          nk_m1 <= HW'(3);
          nr    <= 4'd10;
`endif
        end
        LOAD: begin
          rounds_total <= nr;
          i_q          <= RW'(nk_m1) + RW'(1);
          imod         <= '0;
          rcon         <= 8'h01;
        end
        EXPAND: begin
          for (int unsigned k = 0; k < HIST - 1; k++)
            hist[k[HW-1:0]] <= (k[HW-1:0] == nk_m1) ? w_new : hist[HW'(k + 1)];
          hist[HIST-1] <= w_new;
          i_q  <= i_q + RW'(1);
          imod <= (imod == nk_m1) ? '0 : imod + HW'(1);
          if (imod == '0) rcon <= xtime(rcon);
        end
        default: ;
      endcase
    end

  always_ff @(posedge clk)
    if (state_q == LOAD) begin
      for (int unsigned k = 0; k < HIST; k++)
        if (k[HW-1:0] <= nk_m1) ram[RW'(k)] <= hist[k[HW-1:0]];
    end else if (state_q == EXPAND) begin
      ram[i_q] <= w_new;
    end

  always_comb begin
    rd  = '0;
    idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = RW'({round_key_no, 2'b00}) + RW'(k);
      if (32'(idx) < WORDS_MAX) rd[32*k +: 32] = ram[idx];
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) key <= '0;
    else       key <= rd;

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;
  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic [3:0]   round_key_no;
  logic [127:0] key;
  logic [3:0]   rounds_total;
  logic         busy, key_valid;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [31:0]  mw [60];
  int           m_nk, m_nr;
  logic [127:0] exp_q [$];
  int           tag_q [$];

  localparam logic [255:0] K128 = {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [255:0] K192 = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
                                   32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] K256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                   32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

  aes_key_schedule dut (
    .clk(clk), .reset(reset), .start(start), .key_size(key_size), .key_in(key_in),
    .round_key_no(round_key_no), .key(key), .rounds_total(rounds_total),
    .busy(busy), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = '0;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 byte-oriented expansion; kf holds FIPS word j at [32j+:32]
  task automatic model_expand(input logic [255:0] kf, input logic [1:0] ks);
    logic [7:0] wb [60][4];
    logic [7:0] t [4];
    logic [7:0] tmp, rc;
    int nk, nr;
    case (ks)
`ifdef AES_KEY_256_EN
      2'd1:    begin nk = 6; nr = 12; end
      2'd2:    begin nk = 8; nr = 14; end
`endif
      default: begin nk = 4; nr = 10; end
    endcase
    for (int i = 0; i < nk; i++)
      for (int j = 0; j < 4; j++) wb[i][j] = kf[32*i + 24 - 8*j +: 8];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      for (int j = 0; j < 4; j++) t[j] = wb[i-1][j];
      if (i % nk == 0) begin
        tmp  = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[tmp];
        rc   = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
      end
      for (int j = 0; j < 4; j++) wb[i][j] = wb[i-nk][j] ^ t[j];
    end
    for (int i = 0; i < 4 * (nr + 1); i++) mw[i] = {wb[i][3], wb[i][2], wb[i][1], wb[i][0]};
    m_nk = nk;
    m_nr = nr;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_key(input int r, input logic [127:0] exp);
    logic [127:0] e;
    int tg;
    @(negedge clk);
    round_key_no = 4'(r);
    exp_q.push_back(exp);
    tag_q.push_back(r);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    check($sformatf("round_key_%0d", tg), key, e);
  endtask

  task automatic run_expand(input logic [1:0] ks, input logic [255:0] kf, input bit inject);
    int n, lat;
    model_expand(kf, ks);
    lat = 1 + 4 * (m_nr + 1) - m_nk;
    @(negedge clk);
    key_size = ks;
    for (int j = 0; j < 8; j++) key_in[32*j +: 32] = bswap(kf[32*j +: 32]);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
    check("key_valid_after_start", 128'(key_valid), 128'(0));
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check("rounds_total_after_load", 128'(rounds_total), 128'(m_nr));
      if (inject && n == 5) begin
        start    = 1'b1;
        key_size = 2'd0;
        key_in   = ~key_in;
      end
      if (inject && n == 6) start = 1'b0;
      if (key_valid) break;
    end
    check("latency", 128'(n), 128'(lat));
    check("busy_when_done", 128'(busy), 128'(0));
    for (int r = 0; r <= m_nr; r++)
      read_key(r, {mw[4*r+3], mw[4*r+2], mw[4*r+1], mw[4*r]});
    check("key_valid_held", 128'(key_valid), 128'(1));
  endtask

  initial begin
    logic [255:0] kr;
    reset        = 1'b1;
    start        = 1'b0;
    key_size     = 2'd0;
    key_in       = '0;
    round_key_no = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check("reset_key", key, 128'h0);
    check("reset_rounds_total", 128'(rounds_total), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_key_valid", 128'(key_valid), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    run_expand(2'd0, K128, 1'b0);
    read_key(1, {bswap(32'h2a6c7605), bswap(32'h23a33939), bswap(32'h88542cb1), bswap(32'ha0fafe17)});
    read_key(10, {bswap(32'hb6630ca6), bswap(32'he13f0cc8), bswap(32'hc9ee2589), bswap(32'hd014f9a8)});

    run_expand(2'd2, K256, 1'b0);
`ifdef AES_KEY_256_EN
    @(negedge clk);
    round_key_no = 4'd2;
    @(posedge clk);
    #1;
    check("w8_256", 128'(key[31:0]), 128'(bswap(32'h9ba35411)));
`endif

    run_expand(2'd1, K192, 1'b1);

    @(negedge clk);
    key_size = 2'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_busy", 128'(busy), 128'(0));
    check("midreset_key_valid", 128'(key_valid), 128'(0));
    check("midreset_rounds_total", 128'(rounds_total), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int j = 0; j < 8; j++) kr[32*j +: 32] = $urandom;
    run_expand(2'd3, kr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
